// File: rtl/interrupt_controller_pkg.sv
// rtl/interrupt_controller_pkg.sv - shared state encoding, cfg address map and priority helper
package interrupt_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   localparam logic [3:0] VEC_BASE  = 4'd0;
   localparam logic [3:0] MASK_ADDR = 4'd8;
   localparam logic [3:0] PCLR_ADDR = 4'd9;

   // Bit 0 is the highest priority, so the lowest set index wins.
   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      lowest_set = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) lowest_set = 3'(i);
      end
   endfunction

endpackage

// File: rtl/interrupt_controller_int_sync.sv
// rtl/interrupt_controller_int_sync.sv - 8-bit two-flop synchronizer with rising-edge detect
module int_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] async_in,
   output logic [7:0] rise
);

   logic [7:0] meta;
   logic [7:0] sync;
   logic [7:0] prev;
   logic [1:0] warm;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         sync <= '0;
         prev <= '0;
         warm <= '0;
      end else begin
         meta <= async_in;
         sync <= meta;
         prev <= sync;
         if (warm != 2'd3) warm <= warm + 2'd1;
      end
   end

   // Edges are ignored until prev holds a real sample, so lines already high at reset release never fire.
   assign rise = (warm == 2'd3) ? (sync & ~prev) : 8'h00;

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - 8-line prioritized interrupt controller with vector table
module interrupt_controller
   import interrupt_controller_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  irq,
   output logic        io_interrupt,
   input  logic        io_store_retaddr,
   input  logic        io_push_int_addr,
   input  logic        io_push_retaddr,
   input  logic        io_push_ints,
   input  logic [15:0] d_bus_in,
   input  logic        cfg_we,
   input  logic [3:0]  cfg_addr,
   input  logic [15:0] cfg_data,
   output logic [15:0] data_out,
   output logic        data_oe
);

   state_t      state;
   state_t      next_state;
   logic [7:0]  pending;
   logic [7:0]  mask;
   logic [15:0] vector [8];
   logic [15:0] retaddr;
   logic [2:0]  in_service_id;
   logic [7:0]  rise;
   logic [7:0]  active;
   logic [2:0]  winner;
   logic        take;
   logic [7:0]  clr;
   logic [3:0]  vec_off;

   int_sync u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (irq),
      .rise     (rise)
   );

   assign active  = pending & mask;
   assign winner  = lowest_set(active);
   assign take    = (state == ST_REQ) && io_push_int_addr && (active != 8'h00);
   assign vec_off = cfg_addr - VEC_BASE;
   assign clr     = ((cfg_we && cfg_addr == PCLR_ADDR) ? cfg_data[7:0] : 8'h00)
                  | (take ? (8'h01 << winner) : 8'h00);

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:    if (active != 8'h00) next_state = ST_REQ;
         ST_REQ: begin
            if (take)                   next_state = ST_SERVICE;
            else if (active == 8'h00)   next_state = ST_IDLE;
         end
         ST_SERVICE: if (io_push_retaddr) next_state = ST_IDLE;
         default:                        next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         io_interrupt  <= 1'b0;
         pending       <= '0;
         mask          <= '0;
         retaddr       <= '0;
         in_service_id <= '0;
         for (int i = 0; i < 8; i++) vector[i] <= '0;
      end else begin
         state        <= next_state;
         io_interrupt <= (next_state == ST_REQ);
         // A new edge on a bit being cleared in the same cycle keeps it pending.
         pending      <= (pending & ~clr) | rise;
         if (take) in_service_id <= winner;
         if (io_store_retaddr) retaddr <= d_bus_in;
         if (cfg_we && vec_off < 4'd8) vector[vec_off[2:0]] <= cfg_data;
         if (cfg_we && cfg_addr == MASK_ADDR) mask <= cfg_data[7:0];
      end
   end

   assign data_oe = io_push_int_addr | io_push_retaddr | io_push_ints;

   always_comb begin
      data_out = 16'h0000;
      if (io_push_int_addr)     data_out = take ? vector[winner] : vector[in_service_id];
      else if (io_push_retaddr) data_out = retaddr;
      else if (io_push_ints)    data_out = {mask, pending};
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - randomized scoreboard bench for interrupt_controller
module tb_interrupt_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  irq = 8'h00;
   logic        io_interrupt;
   logic        io_store_retaddr = 1'b0;
   logic        io_push_int_addr = 1'b0;
   logic        io_push_retaddr = 1'b0;
   logic        io_push_ints = 1'b0;
   logic [15:0] d_bus_in = 16'h0000;
   logic        cfg_we = 1'b0;
   logic [3:0]  cfg_addr = 4'h0;
   logic [15:0] cfg_data = 16'h0000;
   logic [15:0] data_out;
   logic        data_oe;

   interrupt_controller dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .irq              (irq),
      .io_interrupt     (io_interrupt),
      .io_store_retaddr (io_store_retaddr),
      .io_push_int_addr (io_push_int_addr),
      .io_push_retaddr  (io_push_retaddr),
      .io_push_ints     (io_push_ints),
      .d_bus_in         (d_bus_in),
      .cfg_we           (cfg_we),
      .cfg_addr         (cfg_addr),
      .cfg_data         (cfg_data),
      .data_out         (data_out),
      .data_oe          (data_oe)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [15:0] exp_q [$];
   logic [15:0] exp_word;

   // Reference model: transaction-level view of the controller.
   logic [7:0]  m_pend, m_mask, m_irq;
   logic [15:0] m_vec [8];
   logic [15:0] m_ret;
   logic        m_busy;
   int          m_isid;

   always @(negedge clk) begin
      if (rst_n) begin
         if (data_oe) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL push_unexpected: data_out=%h with nothing expected", data_out);
            end else begin
               exp_word = exp_q.pop_front();
               if (data_out !== exp_word) begin
                  fails++;
                  $display("FAIL push_data: data_out=%h expected %h", data_out, exp_word);
               end
            end
         end else if (data_out !== 16'h0000) begin
            tests++;
            fails++;
            $display("FAIL idle_data: data_out=%h expected 0000", data_out);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_int();
      check("io_interrupt", {31'd0, io_interrupt}, {31'd0, !m_busy && ((m_pend & m_mask) != 8'h00)});
   endtask

   task automatic model_reset();
      m_pend = 8'h00; m_mask = 8'h00; m_ret = 16'h0000; m_busy = 1'b0; m_isid = 0;
      for (int i = 0; i < 8; i++) m_vec[i] = 16'h0000;
      m_irq = irq;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) step();
   endtask

   task automatic set_irq(input logic [7:0] v);
      m_pend = m_pend | (v & ~m_irq);
      m_irq  = v;
      irq    = v;
      repeat (6) step();
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      step();
      cfg_we = 1'b0;
      if (a < 4'd8)       m_vec[a[2:0]] = d;
      else if (a == 4'd8) m_mask = d[7:0];
      else if (a == 4'd9) m_pend = m_pend & ~d[7:0];
   endtask

   task automatic strobe(input logic ack, input logic ret, input logic ints,
                         input logic store, input logic [15:0] dbus);
      logic       takes;
      takes = ack && !m_busy && ((m_pend & m_mask) != 8'h00);
      if (ack)       exp_q.push_back(takes ? m_vec[lowest(m_pend & m_mask)] : m_vec[m_isid]);
      else if (ret)  exp_q.push_back(m_ret);
      else if (ints) exp_q.push_back({m_mask, m_pend});
      if (takes) begin
         m_isid = lowest(m_pend & m_mask);
         m_pend[m_isid] = 1'b0;
         m_busy = 1'b1;
      end else if (!ack && ret) begin
         m_busy = 1'b0;
      end
      if (store) m_ret = dbus;
      io_push_int_addr = ack; io_push_retaddr = ret; io_push_ints = ints;
      io_store_retaddr = store; d_bus_in = dbus;
      step();
      io_push_int_addr = 1'b0; io_push_retaddr = 1'b0; io_push_ints = 1'b0;
      io_store_retaddr = 1'b0;
   endtask

   initial begin
      model_reset();
      #1;
      check("reset_interrupt", {31'd0, io_interrupt}, 32'd0);
      check("reset_data_oe", {31'd0, data_oe}, 32'd0);
      do_reset();
      check("post_reset_interrupt", {31'd0, io_interrupt}, 32'd0);

      // Single source, exact request latency, vector fetch.
      cfg_write(4'd8, 16'h0004);
      cfg_write(4'd2, 16'h0120);
      irq = 8'h04; m_irq = 8'h04; m_pend = 8'h04;
      repeat (3) step();
      check("latency_3cyc", {31'd0, io_interrupt}, 32'd0);
      step();
      check("latency_4cyc", {31'd0, io_interrupt}, 32'd1);
      strobe(1, 0, 0, 0, 16'h0);
      repeat (3) step();
      check_int();
      strobe(0, 0, 1, 0, 16'h0);
      strobe(0, 0, 0, 1, 16'h0ABC);
      strobe(0, 1, 0, 0, 16'h0);
      repeat (3) step();
      check_int();
      set_irq(8'h00);

      // Priority between simultaneous sources, then follow-up request.
      cfg_write(4'd8, 16'h00FF);
      cfg_write(4'd1, 16'h1111);
      cfg_write(4'd5, 16'h5555);
      set_irq(8'h22);
      check_int();
      strobe(1, 0, 0, 1, 16'h2222);
      repeat (3) step();
      check_int();
      strobe(0, 1, 0, 0, 16'h0);
      repeat (3) step();
      check_int();
      strobe(1, 0, 0, 0, 16'h0);
      strobe(0, 1, 0, 0, 16'h0);
      set_irq(8'h00);

      // Masked pending, late unmask, W1C withdraw.
      do_reset();
      set_irq(8'h08);
      check_int();
      strobe(0, 0, 1, 0, 16'h0);
      cfg_write(4'd8, 16'h0008);
      check("unmask_same", {31'd0, io_interrupt}, 32'd0);
      step();
      check("unmask_next", {31'd0, io_interrupt}, 32'd1);
      cfg_write(4'd9, 16'h0008);
      repeat (2) step();
      check_int();
      strobe(0, 0, 1, 0, 16'h0);

      // Random traffic against the model.
      for (int n = 0; n < 250; n++) begin
         case ($urandom_range(0, 6))
            0: set_irq(8'($urandom));
            1: cfg_write(4'($urandom), 16'($urandom));
            2: cfg_write(4'd8, 16'($urandom));
            3: strobe(1, 0, 0, 1'($urandom), 16'($urandom));
            4: strobe(0, 1, 0, 0, 16'h0);
            5: strobe(0, 0, 1, 1'($urandom), 16'($urandom));
            default: strobe(0, 0, 0, 1, 16'($urandom));
         endcase
         repeat (3) step();
         check_int();
      end

      // Reset in service; lines held high through reset do not fire.
      set_irq(8'h00);
      cfg_write(4'd8, 16'h00FF);
      set_irq(8'h40);
      strobe(1, 0, 0, 0, 16'h0);
      set_irq(8'hFF);
      rst_n = 1'b0;
      #1;
      check("reset_async_interrupt", {31'd0, io_interrupt}, 32'd0);
      do_reset();
      cfg_write(4'd8, 16'h00FF);
      repeat (3) step();
      check_int();
      strobe(0, 0, 1, 0, 16'h0);
      strobe(1, 0, 0, 0, 16'h0);
      strobe(0, 1, 0, 0, 16'h0);

      repeat (2) step();
      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
